// File: rtl/bsg_chip_clk_freq_monitor_if.sv
// Result/request interface for the clock frequency monitor.
//   master : requester side. It drives start_v_i, window_i and yumi_i.
//   slave  : monitor side. It drives start_ready_o, v_o, count_o and overflow_o.
// Signal names follow the monitor's point of view (_i into the monitor,
// _o out of it), whichever modport is in use.
interface bsg_chip_clk_freq_monitor_if #(
    parameter int window_width_p = 16,
    parameter int count_width_p  = 16
);
    logic                      start_v_i;
    logic                      start_ready_o;
    logic [window_width_p-1:0] window_i;
    logic                      v_o;
    logic [count_width_p-1:0]  count_o;
    logic                      overflow_o;
    logic                      yumi_i;

    modport master (
        output start_v_i, window_i, yumi_i,
        input  start_ready_o, v_o, count_o, overflow_o
    );

    modport slave (
        input  start_v_i, window_i, yumi_i,
        output start_ready_o, v_o, count_o, overflow_o
    );
endinterface

// File: rtl/bsg_chip_clk_freq_monitor.sv
// Counts rising plus falling edges of a divided monitored clock over a
// programmable window of reference cycles. The monitored clock must already
// be synchronized to clk_i. The edge count is returned on a valid/yumi result.
//   clk_i    : reference clock; every flop in this block runs on it
//   reset_i  : synchronous, active-high reset
//   toggle_i : monitored divided clock, already in the clk_i domain
//   mon_if   : start request (start_v_i/start_ready_o/window_i) and
//              result (v_o/count_o/overflow_o/yumi_i)
module bsg_chip_clk_freq_monitor #(
    parameter int window_width_p = 16,
    parameter int count_width_p  = 16
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic toggle_i,
    bsg_chip_clk_freq_monitor_if.slave mon_if
);

    typedef enum logic [1:0] {
        eIdle  = 2'd0,
        eArm   = 2'd1,
        eCount = 2'd2,
        eDone  = 2'd3
    } state_e;

    state_e                    r_state;
    state_e                    w_state_n;
    logic [window_width_p-1:0] r_win;
    logic [count_width_p-1:0]  r_count;
    logic                      r_ovf;
    logic                      r_toggle;

    logic w_start;
    logic w_edge;
    logic w_cnt_max;
    logic w_win_zero;
    logic w_win_last;

    assign w_start    = (r_state == eIdle) && mon_if.start_v_i;
    assign w_edge     = (r_state == eCount) && (toggle_i != r_toggle);
    assign w_cnt_max  = &r_count;
    assign w_win_zero = (r_win == '0);
    assign w_win_last = (r_win == window_width_p'(1));

    always_comb begin
        w_state_n = r_state;
        case (r_state)
            eIdle:   if (w_start) w_state_n = eArm;
            eArm:    w_state_n = w_win_zero ? eDone : eCount;
            eCount:  if (w_win_last) w_state_n = eDone;
            eDone:   if (mon_if.yumi_i) w_state_n = eIdle;
            default: w_state_n = eIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state  <= eIdle;
            r_win    <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
            r_toggle <= 1'b0;
        end else begin
            r_state <= w_state_n;
            if (w_start) begin
                r_win   <= mon_if.window_i;
                r_count <= '0;
                r_ovf   <= 1'b0;
            end
            // eArm takes the baseline sample. eCount keeps it one cycle behind.
            if (r_state == eArm || r_state == eCount)
                r_toggle <= toggle_i;
            // r_win is nonzero in every eCount cycle. A window of zero skips eCount.
            if (r_state == eCount)
                r_win <= r_win - window_width_p'(1);
            if (w_edge) begin
                if (w_cnt_max) r_ovf   <= 1'b1;
                else           r_count <= r_count + count_width_p'(1);
            end
        end
    end

    assign mon_if.start_ready_o = (r_state == eIdle);
    assign mon_if.v_o           = (r_state == eDone);
    assign mon_if.count_o       = r_count;
    assign mon_if.overflow_o    = r_ovf;

`ifndef SYNTHESIS
    a_yumi_needs_v : assert property (@(posedge clk_i) disable iff (reset_i)
        mon_if.yumi_i |-> mon_if.v_o);
    a_no_x_ctrl : assert property (@(posedge clk_i) disable iff (reset_i)
        !$isunknown({mon_if.start_v_i, mon_if.yumi_i}));
`endif

endmodule
